// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared types and widths for the accelerator datapath blocks.
//   ADDR_WIDTH     : width of scratchpad addresses
//   DATA_WIDTH     : width of scratchpad read data
//   CNT_WIDTH      : width of job length / beat counters
//   reader_state_e : control states of addr_stream_reader
// ---------------------------------------------------------------------------
package accel_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } reader_state_e;

endpackage

// File: rtl/rd_data_fifo.sv
// ---------------------------------------------------------------------------
// rd_data_fifo
// Synchronous first-word-fall-through FIFO that holds returned read data.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push_i, data_i  : write strobe and write data
//   pop_i           : removes the head entry (ignored when empty)
//   data_o          : head entry, zero while empty
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries
// ---------------------------------------------------------------------------
module rd_data_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : storage_q[rdPtr_q];

    // A push into a full FIFO is allowed only when the head leaves in the
    // same cycle; the freed slot is exactly the one the write pointer names.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            assert (!(push_i && full_o && !doPop));
        end
    end

    // Data storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/addr_stream_reader.sv
// ---------------------------------------------------------------------------
// addr_stream_reader
// Accepts addresses from the address generator, issues one scratchpad read
// per address and returns the data in order on a valid/ready stream.
// A credit check (reads in flight + FIFO occupancy) keeps the output FIFO
// from ever overflowing.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start, length               : job start pulse and beat count
//   busy, done                  : job in progress, job finished pulse
//   addr, addr_valid, addr_ready: incoming address stream
//   mem_en, mem_addr, mem_rdata : scratchpad read port
//   data_out, data_valid,
//   data_ready, data_last       : outgoing data stream
// ---------------------------------------------------------------------------
module addr_stream_reader
    import accel_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  addr_valid,
    output logic                  addr_ready,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reader_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  length_q, length_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  popped_q, popped_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [READ_LATENCY-1:0] readPipe_q, readPipe_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  pushEn;
    logic                  popEn;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [CW-1:0]         fifoCount;
    logic [CW:0]           creditUsed;

    rd_data_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushEn),
        .data_i  (mem_rdata),
        .pop_i   (popEn),
        .data_o  (data_out),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Every read either sits in the latency pipe or in the FIFO, so their
    // sum is the number of FIFO slots already promised.
    assign creditUsed = {1'b0, inflight_q} + {1'b0, fifoCount};

    assign addr_ready = (state_q == RD_RUN) && (issued_q < length_q)
                        && (creditUsed < (CW+1)'(FIFO_DEPTH));
    assign accept     = addr_valid && addr_ready;
    assign mem_en     = accept;
    assign mem_addr   = accept ? addr : '0;

    assign pushEn     = readPipe_q[READ_LATENCY-1];
    assign data_valid = !fifoEmpty;
    assign popEn      = data_valid && data_ready;
    assign data_last  = data_valid && (popped_q == length_q - 1'b1);
    assign busy       = (state_q != RD_IDLE);
    assign done       = done_q;

    // Next-state logic: job control, beat counters, credits and the read
    // latency pipe. The credit rule means pushEn never meets a full FIFO.
    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        issued_d   = issued_q + CNT_WIDTH'(accept);
        popped_d   = popped_q + CNT_WIDTH'(popEn);
        inflight_d = inflight_q;
        done_d     = 1'b0;
        readPipe_d = '0;

        readPipe_d[0] = accept;
        for (int i = 1; i < READ_LATENCY; i++) begin
            readPipe_d[i] = readPipe_q[i-1];
        end

        case ({accept, pushEn})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d  = RD_RUN;
                        length_d = length;
                        issued_d = '0;
                        popped_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD_RUN: begin
                if (issued_q == length_q) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (popEn && data_last) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State register; reset drops any reads still in the latency pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            length_q   <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= '0;
            readPipe_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            readPipe_q <= readPipe_d;
            done_q     <= done_d;
        end
    end

endmodule
